// File: rtl/ulpi_rx_framer.sv
// Frames the ULPI link-layer receive byte stream into SOP/EOP/ERR-marked packets
// delivered through a first-word-fall-through FIFO with valid/ready handshake.
module ulpi_rx_framer #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  data,
  input  logic        data_valid,
  input  logic [7:0]  rx_cmd,
  output logic [7:0]  out_data,
  output logic        out_sop,
  output logic        out_eop,
  output logic        out_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  line_state,
  output logic [15:0] drop_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACTIVE  = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  typedef struct packed {
    logic       err;
    logic       eop;
    logic       sop;
    logic [7:0] data;
  } beat_t;

  state_t state_reg, state_next;

  logic [7:0]  hold_data_reg;
  logic        hold_sop_reg;
  logic        hold_vld_reg;
  logic        first_reg;
  logic        err_flag_reg;
  logic [15:0] drop_count_reg;
  logic [1:0]  line_state_reg;

  beat_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  wr_ptr_plus1;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [CNT_W-1:0]  free_cnt;
  logic [CNT_W-1:0]  wr_cnt;

  logic rx_active;
  logic rx_error;
  logic room_one;
  logic room_two;
  logic pop;

  logic  wr0_en, wr1_en;
  beat_t wr0_beat, wr1_beat;
  beat_t held_beat, term_beat, head;
  logic  hold_load, hold_clear, overflow, drop;

  logic [FIFO_DEPTH-1:0] sel0, sel1;

  logic unused_rx_cmd_bits;
  assign unused_rx_cmd_bits = &{1'b0, rx_cmd[7:6], rx_cmd[3:2]};

  assign rx_active = rx_cmd[4];
  assign rx_error  = (rx_cmd[5:4] == 2'b11);

  assign free_cnt     = DEPTH_C - count_reg;
  assign room_one     = (free_cnt != '0);
  assign room_two     = (free_cnt >= CNT_W'(2));
  assign out_valid    = (count_reg != '0);
  assign pop          = out_valid & out_ready;
  assign wr_ptr_plus1 = wr_ptr_reg + PTR_W'(1);
  assign wr_cnt       = CNT_W'(wr0_en) + CNT_W'(wr1_en);

  assign held_beat = {1'b0, 1'b0, hold_sop_reg, hold_data_reg};
  // Overflow terminator: the reserved last slot closes the packet as bad.
  assign term_beat = {1'b1, 1'b1, hold_sop_reg, hold_data_reg};

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (rx_active) state_next = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (!rx_active)    state_next = S_IDLE;
        else if (overflow) state_next = S_DISCARD;
      end
      S_DISCARD: begin
        if (!rx_active) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Output / push decisions
  always_comb begin
    wr0_en     = 1'b0;
    wr0_beat   = '0;
    wr1_en     = 1'b0;
    wr1_beat   = '0;
    hold_load  = 1'b0;
    hold_clear = 1'b0;
    overflow   = 1'b0;
    drop       = 1'b0;
    if (state_reg == S_ACTIVE) begin
      if (!rx_active) begin
        hold_clear = 1'b1;
        if (data_valid && hold_vld_reg) begin
          // Byte arriving with the falling edge is the last one: two writes.
          if (room_two) begin
            wr0_en   = 1'b1;
            wr0_beat = held_beat;
            wr1_en   = 1'b1;
            wr1_beat = {err_flag_reg, 1'b1, 1'b0, data};
          end else begin
            drop = 1'b1;
            if (room_one) begin
              wr0_en   = 1'b1;
              wr0_beat = term_beat;
            end
          end
        end else if (data_valid) begin
          if (room_one) begin
            wr0_en   = 1'b1;
            wr0_beat = {err_flag_reg, 1'b1, first_reg, data};
          end else begin
            drop = 1'b1;
          end
        end else if (hold_vld_reg) begin
          if (room_one) begin
            wr0_en   = 1'b1;
            wr0_beat = {err_flag_reg, 1'b1, hold_sop_reg, hold_data_reg};
          end else begin
            drop = 1'b1;
          end
        end
      end else if (data_valid) begin
        if (!hold_vld_reg || room_two) begin
          hold_load = 1'b1;
          if (hold_vld_reg) begin
            wr0_en   = 1'b1;
            wr0_beat = held_beat;
          end
        end else begin
          overflow   = 1'b1;
          drop       = 1'b1;
          hold_clear = 1'b1;
          if (room_one) begin
            wr0_en   = 1'b1;
            wr0_beat = term_beat;
          end
        end
      end
    end
  end

  // Framing datapath: hold register, packet flags, status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_data_reg  <= '0;
      hold_sop_reg   <= 1'b0;
      hold_vld_reg   <= 1'b0;
      first_reg      <= 1'b0;
      err_flag_reg   <= 1'b0;
      drop_count_reg <= '0;
      line_state_reg <= '0;
    end else begin
      line_state_reg <= rx_cmd[1:0];
      if (state_reg == S_IDLE && rx_active) begin
        first_reg    <= 1'b1;
        err_flag_reg <= 1'b0;
      end
      if (state_reg == S_ACTIVE && rx_error) begin
        err_flag_reg <= 1'b1;
      end
      if (hold_load) begin
        hold_data_reg <= data;
        hold_sop_reg  <= first_reg;
        hold_vld_reg  <= 1'b1;
        first_reg     <= 1'b0;
      end else if (hold_clear) begin
        hold_vld_reg <= 1'b0;
      end
      if (drop && drop_count_reg != 16'hFFFF) begin
        drop_count_reg <= drop_count_reg + 16'd1;
      end
    end
  end

  // FIFO pointers and occupancy; up to two writes and one read per cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + PTR_W'(wr_cnt);
      rd_ptr_reg <= rd_ptr_reg + PTR_W'(pop);
      count_reg  <= count_reg + wr_cnt - CNT_W'(pop);
    end
  end

  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_wsel
    assign sel0[gi] = wr0_en && (wr_ptr_reg == PTR_W'(gi));
    assign sel1[gi] = wr1_en && (wr_ptr_plus1 == PTR_W'(gi));
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (sel0[i])      mem[i] <= wr0_beat;
      else if (sel1[i]) mem[i] <= wr1_beat;
    end
  end

  // Head is gated so the outputs read zero while the FIFO is empty
  assign head       = mem[rd_ptr_reg];
  assign out_data   = out_valid ? head.data : 8'h00;
  assign out_sop    = out_valid & head.sop;
  assign out_eop    = out_valid & head.eop;
  assign out_err    = out_valid & head.err;
  assign line_state = line_state_reg;
  assign drop_count = drop_count_reg;

endmodule

// File: tb/tb_ulpi_rx_framer.sv
// Directed bench for ulpi_rx_framer: per-cycle vector table plus packet-level
// sequences for RxError, overflow, backpressure and mid-packet reset.
module tb_ulpi_rx_framer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  data;
  logic        data_valid;
  logic [7:0]  rx_cmd;
  logic [7:0]  out_data;
  logic        out_sop, out_eop, out_err, out_valid, out_ready;
  logic [1:0]  line_state;
  logic [15:0] drop_count;

  logic        ready_manual;
  logic        bp_mode;
  logic        bp_ready = 1'b1;
  logic [15:0] bp_mask = 16'b1001_1011_0010_1101;
  int          bp_idx = 0;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       sop;
    logic       eop;
    logic       err;
  } beat_t;

  typedef struct packed {
    logic [7:0] cmd;
    logic       dv;
    logic [7:0] d;
    logic       rdy;
    logic       e_valid;
    logic [7:0] e_data;
    logic       e_sop;
    logic       e_eop;
    logic       e_err;
    logic [1:0] e_ls;
  } vec_t;

  beat_t      beats[$];
  beat_t      stall_snap;
  logic       stall_pending = 1'b0;
  int         stall_viol = 0;
  int         stall_seen = 0;
  logic [7:0] pkt [16];
  vec_t       vecs [15];

  always #5 clk = ~clk;

  assign out_ready = bp_mode ? bp_ready : ready_manual;

  ulpi_rx_framer #(.FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .data       (data),
    .data_valid (data_valid),
    .rx_cmd     (rx_cmd),
    .out_data   (out_data),
    .out_sop    (out_sop),
    .out_eop    (out_eop),
    .out_err    (out_err),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .line_state (line_state),
    .drop_count (drop_count)
  );

  always @(negedge clk) begin
    bp_ready = bp_mask[bp_idx[3:0]];
    bp_idx   = bp_idx + 1;
  end

  // Collects accepted beats and tracks head stability while stalled
  always @(posedge clk) begin
    beat_t cur;
    cur = {out_data, out_sop, out_eop, out_err};
    if (stall_pending && out_valid) begin
      stall_seen++;
      if (cur != stall_snap) stall_viol++;
    end
    stall_pending = out_valid && !out_ready;
    stall_snap    = cur;
    if (out_valid && out_ready) beats.push_back(cur);
  end

  function automatic vec_t mk(input logic [7:0] c, input logic v, input logic [7:0] d,
                              input logic r, input logic ev, input logic [7:0] ed,
                              input logic es, input logic ee, input logic er,
                              input logic [1:0] el);
    return {c, v, d, r, ev, ed, es, ee, er, el};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] c, input logic v, input logic [7:0] d);
    @(negedge clk);
    rx_cmd     = c;
    data_valid = v;
    data       = d;
  endtask

  task automatic send_pkt(input int n, input int gap, input int err_at);
    drive(8'h10, 1'b0, 8'h00);
    for (int i = 0; i < n; i++) begin
      drive((i == err_at) ? 8'h30 : 8'h10, 1'b1, pkt[i]);
      for (int g = 0; g < gap; g++) drive(8'h10, 1'b0, 8'h00);
    end
    drive(8'h00, 1'b0, 8'h00);
    drive(8'h00, 1'b0, 8'h00);
  endtask

  task automatic check_pkt(input string name, input int base, input int n, input logic exp_err);
    int t;
    t = 0;
    while (beats.size() < base + n && t < 200) begin
      @(posedge clk);
      t++;
    end
    repeat (4) @(posedge clk);
    check({name, " beat count"}, beats.size() - base, n);
    for (int i = 0; i < n && base + i < beats.size(); i++) begin
      beat_t e;
      e = {pkt[i], (i == 0), (i == n - 1), (exp_err && (i == n - 1))};
      check($sformatf("%s beat%0d", name, i), beats[base + i], e);
      $display("%s beat%0d: data=%02h sop=%0b eop=%0b err=%0b", name, i,
               beats[base + i].d, beats[base + i].sop, beats[base + i].eop, beats[base + i].err);
    end
  endtask

  initial begin
    int base;
    int k;
    int lens [4];

    reset_n      = 1'b0;
    rx_cmd       = 8'h13;
    data         = 8'h00;
    data_valid   = 1'b0;
    ready_manual = 1'b1;
    bp_mode      = 1'b0;

    // cmd, dv, data, ready | valid, data, sop, eop, err, line_state (after the edge)
    vecs[0]  = mk(8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0);
    vecs[1]  = mk(8'h11, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd1);
    vecs[2]  = mk(8'h11, 1'b1, 8'hC3, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd1);
    vecs[3]  = mk(8'h11, 1'b1, 8'h11, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b0, 1'b0, 2'd1);
    vecs[4]  = mk(8'h11, 1'b1, 8'h22, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 2'd1);
    vecs[5]  = mk(8'h01, 1'b0, 8'h00, 1'b1, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 2'd1);
    vecs[6]  = mk(8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0);
    vecs[7]  = mk(8'h10, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0);
    vecs[8]  = mk(8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0);
    vecs[9]  = mk(8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0);
    vecs[10] = mk(8'h10, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0);
    vecs[11] = mk(8'h00, 1'b1, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 2'd0);
    vecs[12] = mk(8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 2'd0);
    vecs[13] = mk(8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0);
    vecs[14] = mk(8'h00, 1'b1, 8'h77, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0);

    repeat (3) @(posedge clk);
    #1;
    check("reset outputs",
          {out_valid, out_data, out_sop, out_eop, out_err, line_state, drop_count}, 64'd0);
    $display("reset: valid=%0b ls=%0d drop=%0d", out_valid, line_state, drop_count);
    @(negedge clk);
    rx_cmd  = 8'h00;
    reset_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      rx_cmd       = vecs[i].cmd;
      data_valid   = vecs[i].dv;
      data         = vecs[i].d;
      ready_manual = vecs[i].rdy;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i),
            {out_valid, out_data, out_sop, out_eop, out_err, line_state},
            {vecs[i].e_valid, vecs[i].e_data, vecs[i].e_sop, vecs[i].e_eop,
             vecs[i].e_err, vecs[i].e_ls});
      $display("vec%0d: cmd=%02h dv=%0b d=%02h rdy=%0b -> valid=%0b data=%02h sop=%0b eop=%0b err=%0b ls=%0d",
               i, vecs[i].cmd, vecs[i].dv, vecs[i].d, vecs[i].rdy,
               out_valid, out_data, out_sop, out_eop, out_err, line_state);
    end
    check("drop after table", drop_count, 16'd0);

    // RxError for one cycle mid-packet
    ready_manual = 1'b1;
    pkt[0] = 8'h01; pkt[1] = 8'h02; pkt[2] = 8'h03; pkt[3] = 8'h04;
    base = beats.size();
    send_pkt(4, 0, 1);
    check_pkt("rxerr", base, 4, 1'b1);

    // Overflow of a depth-4 FIFO with no consumer
    ready_manual = 1'b0;
    for (int i = 0; i < 10; i++) pkt[i] = 8'h40 + 8'(i);
    base = beats.size();
    send_pkt(10, 0, -1);
    check("ovf drop_count", drop_count, 16'd1);
    ready_manual = 1'b1;
    check_pkt("ovf", base, 4, 1'b1);

    pkt[0] = 8'h5A; pkt[1] = 8'h5B; pkt[2] = 8'h5C;
    base = beats.size();
    send_pkt(3, 0, -1);
    check_pkt("post_ovf", base, 3, 1'b0);

    // Back-to-back packets under a fixed stall pattern
    bp_mode = 1'b1;
    lens[0] = 2; lens[1] = 5; lens[2] = 3; lens[3] = 6;
    k = 0;
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < lens[p]; i++) begin
        pkt[i] = 8'h80 + 8'(k);
        k++;
      end
      base = beats.size();
      send_pkt(lens[p], 2, -1);
      check_pkt($sformatf("bp%0d", p), base, lens[p], 1'b0);
    end
    bp_mode = 1'b0;
    check("bp drop_count", drop_count, 16'd1);
    check("stall stability violations", stall_viol, 0);
    check("stalls observed", (stall_seen > 0), 1'b1);

    // Reset mid-packet
    ready_manual = 1'b0;
    drive(8'h10, 1'b0, 8'h00);
    drive(8'h10, 1'b1, 8'h61);
    drive(8'h10, 1'b1, 8'h62);
    drive(8'h10, 1'b0, 8'h00);
    check("pre-reset valid", out_valid, 1'b1);
    #1 reset_n = 1'b0;
    #1;
    check("async reset valid", out_valid, 1'b0);
    check("async reset drop_count", drop_count, 16'd0);
    $display("mid-packet reset: valid=%0b drop=%0d", out_valid, drop_count);
    rx_cmd     = 8'h00;
    data_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset_n      = 1'b1;
    ready_manual = 1'b1;
    pkt[0] = 8'h71; pkt[1] = 8'h72; pkt[2] = 8'h73;
    base = beats.size();
    send_pkt(3, 0, -1);
    check_pkt("post_reset", base, 3, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ulpi_rx_framer.md
# ulpi_rx_framer

Downstream consumer of the ULPI link layer's receive outputs (`data`, `data_valid`, `rx_cmd`). It turns the raw byte stream and RX CMD status into framed USB packets. Each packet is delivered through a first-word-fall-through FIFO with start-of-packet, end-of-packet and error markers on a valid/ready stream. It also exports the current line state and a saturating count of dropped packets.

## Interface
- `FIFO_DEPTH`, default 16: output FIFO entries; power of two, ≥4.
- `clk`  in  1  link clock, the same clock that drives the link-layer outputs.
- `reset_n`  in  1  asynchronous, active-low reset.
- `data`  in  8  received byte from the link layer.
- `data_valid`  in  1  one-cycle strobe per received byte.
- `rx_cmd`  in  8  latest RX CMD:
  - [1:0] LineState
  - [3:2] VbusState
  - [5:4] RxEvent (01 = active, 11 = active + error)
- `out_data`  out  8  packet byte.
- `out_sop`  out  1  first byte of packet.
- `out_eop`  out  1  last byte of packet.
- `out_err`  out  1  packet bad (RxError or truncation); valid only when `out_eop`=1.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  consumer accepts head when `out_valid`&`out_ready`.
- `line_state`  out  2  registered `rx_cmd[1:0]`.
- `drop_count`  out  16  packets truncated by overflow; saturates at 0xFFFF.

## Operation
- Derived signals, combinational from `rx_cmd`:
  - `rx_active` = `rx_cmd[4]`
  - `rx_error` = (`rx_cmd[5:4]` == 2'b11)
- One-byte hold register (`hold_data`, `hold_sop`, `hold_vld`) delays each byte so that `eop` can be attached to the last byte.
- State machine:
  - IDLE: `data_valid` is ignored. On `rx_active`=1:
    - go to ACTIVE;
    - clear `err_flag`;
    - set `first`=1.
  - ACTIVE, on each `data_valid`:
    - if `hold_vld`, push the hold register (`eop`=0) into the FIFO;
    - load `data` into the hold register with `sop`=`first`;
    - clear `first`.
  - ACTIVE, error tracking: `rx_error` in any cycle sets `err_flag`.
  - ACTIVE, on `rx_active`=0:
    - if `hold_vld`, push it with `eop`=1 and `err`=`err_flag`;
    - go to IDLE.
    - If no byte was received, nothing is pushed (zero-length activity is discarded silently).
  - Overflow rule. A push of a non-final byte while the FIFO has exactly one free entry is converted:
    - the held byte is pushed with `eop`=1, `err`=1;
    - `hold_vld` is cleared;
    - `drop_count` increments;
    - the block enters DISCARD.
    - The free slot is always reserved for a terminator, so every packet in the FIFO ends with `eop`.
  - DISCARD: ignore bytes; on `rx_active`=0 go to IDLE.
- Simultaneous `data_valid` and `rx_active` falling: the byte belongs to the packet and becomes its last byte. It is pushed directly with `eop`=1, and the previously held byte is pushed in the same cycle. The FIFO therefore supports two writes per cycle, or an equivalent write path that is never lost.
- Simultaneous push and pop is allowed; occupancy is unchanged.
- `line_state` updates every cycle, independent of state.

## Timing
- Reset (asynchronous assert, synchronous-safe release) sets:
  - `out_valid`=0, `out_data`=0, `out_sop`=0, `out_eop`=0, `out_err`=0;
  - `line_state`=0, `drop_count`=0;
  - FIFO empty, hold register cleared, state IDLE.
- Reset mid-packet discards all partial and buffered data.
- Latency:
  - A byte is written into the FIFO on the clock after its successor's `data_valid`, or on the clock after `rx_active` falls.
  - `out_valid` rises the cycle after the write.
  - The last byte is visible at most 2 cycles after the falling edge of `rx_active`.
- `out_*` holds stable while `out_valid`=1 and `out_ready`=0.
- `rx_active` is sampled every cycle. A one-cycle drop ends the packet.
- `drop_count` increments on the cycle DISCARD is entered.

## Test plan
- Basic packet: `rx_active`=1, bytes 0xC3, 0x11, 0x22, then `rx_active`=0, `out_ready`=1 → three beats; `sop` on 0xC3, `eop`=1 with `err`=0 on 0x22.
- RxError: 4-byte packet with `rx_cmd[5:4]`=11 for one cycle mid-packet → last beat has `eop`=1, `err`=1; no other beat has `err`.
- Overflow: `FIFO_DEPTH`=4, `out_ready`=0, 10-byte packet → FIFO holds 4 beats, 4th has `eop`=1, `err`=1; `drop_count`=1. After draining, the next packet is clean.
- Zero-length and simultaneous end:
  - `rx_active` pulse with no bytes → no output.
  - Single byte 0xA5 with `data_valid` on the same cycle `rx_active` falls → one beat with `sop`=1, `eop`=1.
- Backpressure: toggle `out_ready` randomly over back-to-back packets → byte order preserved, no loss, outputs stable while stalled.
- Reset mid-packet: assert `reset_n`=0 after 2 bytes → `out_valid`=0 immediately. After release, the next packet is output from its `sop` correctly.
